// File: rtl/gin_pkg.sv
// rtl/gin_pkg.sv - shared types and helpers for the GIN bus controller
//
// Purpose: controller state encoding, the wildcard-tag helper and the
//          length of the ID programming sequence.
// Ports:   none (package).
package gin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PROG  = 2'd2,
    ST_RUN   = 2'd3
  } gin_state_t;

  localparam int GRID_X_DEF = 10;
  localparam int GRID_Y_DEF = 10;
  localparam int CFG_LEN    = GRID_Y_DEF + GRID_Y_DEF * GRID_X_DEF;

  // Programming length for any grid: GRID_Y row IDs followed by every col ID.
  function automatic int cfg_len(input int grid_x, input int grid_y);
    return grid_y + grid_y * grid_x;
  endfunction

  // True when the low w bits of tag are all ones (w <= 8).
  function automatic logic is_wildcard(input logic [7:0] tag, input int unsigned w);
    logic [7:0] mask;
    mask = (8'd1 << w) - 8'd1;
    return (tag & mask) == mask;
  endfunction

endpackage

// File: rtl/gin_row_ctrl.sv
// rtl/gin_row_ctrl.sv - one PE row: ID storage, tag match and row readiness
//
// Purpose: stores one row ID and GRID_X col IDs, matches the incoming tags
//          against them, and reports whether all current targets in the row
//          are ready.
// Ports:   i_clk/i_rstb       clock, async active-low reset
//          i_row_we/i_col_we  ID write strobes (col one-hot per PE)
//          i_row_wdata/i_col_wdata  truncated cfg_id
//          i_row_tag/i_col_tag      tags of the word on the input port
//          i_tgt              registered enable_x of this row (current targets)
//          i_pe_ready         per-PE ready of this row
//          o_en_y/o_en_x      combinational match enables for the input word
//          o_row_ready        every target in this row is ready
module gin_row_ctrl
  import gin_pkg::*;
#(
  parameter int GRID_X   = 10,
  parameter int ROW_ID_W = 4,
  parameter int COL_ID_W = 5
) (
  input  logic                i_clk,
  input  logic                i_rstb,
  input  logic                i_row_we,
  input  logic [GRID_X-1:0]   i_col_we,
  input  logic [ROW_ID_W-1:0] i_row_wdata,
  input  logic [COL_ID_W-1:0] i_col_wdata,
  input  logic [ROW_ID_W-1:0] i_row_tag,
  input  logic [COL_ID_W-1:0] i_col_tag,
  input  logic [GRID_X-1:0]   i_tgt,
  input  logic [GRID_X-1:0]   i_pe_ready,
  output logic [GRID_X-1:0]   o_en_y,
  output logic [GRID_X-1:0]   o_en_x,
  output logic                o_row_ready
);

  logic [ROW_ID_W-1:0] r_row_id;
  logic [COL_ID_W-1:0] r_col_id [GRID_X];
  logic                w_row_hit;
  logic                w_col_wild;

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_row_id <= '0;
      for (int c = 0; c < GRID_X; c++) r_col_id[c] <= '0;
    end else begin
      if (i_row_we) r_row_id <= i_row_wdata;
      for (int c = 0; c < GRID_X; c++) begin
        if (i_col_we[c]) r_col_id[c] <= i_col_wdata;
      end
    end
  end

  assign w_row_hit  = is_wildcard(8'(i_row_tag), ROW_ID_W) | (i_row_tag == r_row_id);
  assign w_col_wild = is_wildcard(8'(i_col_tag), COL_ID_W);

  always_comb begin
    o_en_x = '0;
    for (int c = 0; c < GRID_X; c++) begin
      o_en_x[c] = w_row_hit & (w_col_wild | (i_col_tag == r_col_id[c]));
    end
  end

  assign o_en_y = {GRID_X{w_row_hit}};

  // Non-targets are masked out so their readiness never stalls the word.
  assign o_row_ready = &(~i_tgt | i_pe_ready);

endmodule

// File: rtl/gin_bus_controller.sv
// rtl/gin_bus_controller.sv - GIN controller multicasting tagged words to the PE array
//
// Purpose: programs per-PE row/col IDs serially, then accepts tagged words and
//          presents each to the PEs whose IDs match, holding it until every
//          target is ready.
// Ports:   i_clk/i_rstb         clock, async active-low reset
//          i_prog_start         begin (or restart) ID programming
//          i_cfg_valid/i_cfg_id ID stream, rows first then cols row-major
//          o_prog_done          pulse when the last ID is stored
//          i_in_valid/o_in_ready, i_in_data, i_in_row_tag, i_in_col_tag  input word
//          o_out_data/o_out_valid  word presented to the array
//          o_enable_y/o_enable_x   per-PE enables, index r*GRID_X+c
//          i_pe_ready           per-PE ready
//          o_nomatch            pulse: accepted word had no target
module gin_bus_controller
  import gin_pkg::*;
#(
  parameter int BITWIDTH = 16,
  parameter int GRID_X   = 10,
  parameter int GRID_Y   = 10,
  parameter int ROW_ID_W = 4,
  parameter int COL_ID_W = 5,
  parameter int CFG_W    = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rstb,
  input  logic                       i_prog_start,
  input  logic                       i_cfg_valid,
  input  logic [CFG_W-1:0]           i_cfg_id,
  output logic                       o_prog_done,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic signed [BITWIDTH-1:0] i_in_data,
  input  logic [ROW_ID_W-1:0]        i_in_row_tag,
  input  logic [COL_ID_W-1:0]        i_in_col_tag,
  output logic signed [BITWIDTH-1:0] o_out_data,
  output logic                       o_out_valid,
  output logic [GRID_X*GRID_Y-1:0]   o_enable_y,
  output logic [GRID_X*GRID_Y-1:0]   o_enable_x,
  input  logic [GRID_X*GRID_Y-1:0]   i_pe_ready,
  output logic                       o_nomatch
);

  localparam int NPE = GRID_X * GRID_Y;
  localparam int LEN = cfg_len(GRID_X, GRID_Y);
  localparam int K_W = $clog2(LEN);

  gin_state_t                 r_state;
  logic [K_W-1:0]             r_k;
  logic signed [BITWIDTH-1:0] r_out_data;
  logic                       r_out_valid;
  logic [NPE-1:0]             r_en_x;
  logic [NPE-1:0]             r_en_y;
  logic                       r_prog_done;
  logic                       r_nomatch;

  logic [NPE-1:0]    w_en_x;
  logic [NPE-1:0]    w_en_y;
  logic [GRID_Y-1:0] w_row_ready;
  logic              w_fire;
  logic              w_accept;
  logic              w_cfg_wr;
  logic              w_last;
  logic              w_any_tgt;

  assign w_fire     = r_out_valid & (&w_row_ready);
  assign o_in_ready = (r_state == ST_RUN) & (~r_out_valid | w_fire);
  assign w_accept   = i_in_valid & o_in_ready;
  // prog_start wins over a coincident cfg word: the restart discards it.
  assign w_cfg_wr   = (r_state == ST_PROG) & i_cfg_valid & ~i_prog_start;
  assign w_last     = (r_k == K_W'(LEN - 1));
  assign w_any_tgt  = |w_en_x;

  for (genvar r = 0; r < GRID_Y; r++) begin : g_row
    logic [GRID_X-1:0] w_col_we;
    logic              w_row_we;

    assign w_row_we = w_cfg_wr & (r_k == K_W'(r));
    for (genvar c = 0; c < GRID_X; c++) begin : g_col
      assign w_col_we[c] = w_cfg_wr & (r_k == K_W'(GRID_Y + r * GRID_X + c));
    end

    gin_row_ctrl #(
      .GRID_X  (GRID_X),
      .ROW_ID_W(ROW_ID_W),
      .COL_ID_W(COL_ID_W)
    ) u_row (
      .i_clk      (i_clk),
      .i_rstb     (i_rstb),
      .i_row_we   (w_row_we),
      .i_col_we   (w_col_we),
      .i_row_wdata(i_cfg_id[ROW_ID_W-1:0]),
      .i_col_wdata(i_cfg_id[COL_ID_W-1:0]),
      .i_row_tag  (i_in_row_tag),
      .i_col_tag  (i_in_col_tag),
      .i_tgt      (r_en_x[r*GRID_X +: GRID_X]),
      .i_pe_ready (i_pe_ready[r*GRID_X +: GRID_X]),
      .o_en_y     (w_en_y[r*GRID_X +: GRID_X]),
      .o_en_x     (w_en_x[r*GRID_X +: GRID_X]),
      .o_row_ready(w_row_ready[r])
    );
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_en_x      <= '0;
      r_en_y      <= '0;
      r_prog_done <= 1'b0;
      r_nomatch   <= 1'b0;
    end else begin
      r_prog_done <= 1'b0;
      r_nomatch   <= 1'b0;

      // A new word in the same edge as a fire simply replaces the old one.
      if (w_accept) begin
        r_out_data  <= i_in_data;
        r_en_x      <= w_en_x;
        r_en_y      <= w_en_y;
        r_out_valid <= w_any_tgt;
        r_nomatch   <= ~w_any_tgt;
      end else if (w_fire) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_prog_start) begin
            r_state <= ST_PROG;
            r_k     <= '0;
          end
        end
        ST_RUN: begin
          if (i_prog_start) begin
            r_k     <= '0;
            r_state <= (r_out_valid | w_accept) ? ST_DRAIN : ST_PROG;
          end
        end
        ST_DRAIN: begin
          if (!r_out_valid || w_fire) r_state <= ST_PROG;
        end
        ST_PROG: begin
          if (i_prog_start) begin
            r_k <= '0;
          end else if (i_cfg_valid) begin
            if (w_last) begin
              r_k         <= '0;
              r_prog_done <= 1'b1;
              r_state     <= ST_RUN;
            end else begin
              r_k <= r_k + K_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_enable_x  = r_en_x;
  assign o_enable_y  = r_en_y;
  assign o_prog_done = r_prog_done;
  assign o_nomatch   = r_nomatch;

endmodule

// File: tb/tb_gin_bus_controller.sv
// tb/tb_gin_bus_controller.sv - self-checking bench for gin_bus_controller
module tb_gin_bus_controller;
  import gin_pkg::*;

  localparam int GX  = 10;
  localparam int GY  = 10;
  localparam int NPE = GX * GY;

  logic              i_clk = 1'b0;
  logic              i_rstb = 1'b0;
  logic              i_prog_start = 1'b0;
  logic              i_cfg_valid = 1'b0;
  logic [4:0]        i_cfg_id = '0;
  logic              o_prog_done;
  logic              i_in_valid = 1'b0;
  logic              o_in_ready;
  logic signed [15:0] i_in_data = '0;
  logic [3:0]        i_in_row_tag = '0;
  logic [4:0]        i_in_col_tag = '0;
  logic signed [15:0] o_out_data;
  logic              o_out_valid;
  logic [NPE-1:0]    o_enable_y;
  logic [NPE-1:0]    o_enable_x;
  logic [NPE-1:0]    i_pe_ready = '1;
  logic              o_nomatch;

  int checks = 0;
  int failures = 0;

  int m_row_id [GY];
  int m_col_id [GY][GX];

  gin_bus_controller dut (
    .i_clk       (i_clk),
    .i_rstb      (i_rstb),
    .i_prog_start(i_prog_start),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_id    (i_cfg_id),
    .o_prog_done (o_prog_done),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .i_in_row_tag(i_in_row_tag),
    .i_in_col_tag(i_in_col_tag),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .o_enable_y  (o_enable_y),
    .o_enable_x  (o_enable_x),
    .i_pe_ready  (i_pe_ready),
    .o_nomatch   (o_nomatch)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Expected enables from the ID tables: every PE in a matching row sees
  // enable_y; it is a target only if its col ID matches as well.
  function automatic void calc_en(input int rt, input int ct,
                                  output logic [NPE-1:0] ey, output logic [NPE-1:0] ex);
    ey = '0;
    ex = '0;
    for (int r = 0; r < GY; r++) begin
      for (int c = 0; c < GX; c++) begin
        bit rh;
        bit ch;
        rh = (rt == 15) || (rt == m_row_id[r]);
        ch = (ct == 31) || (ct == m_col_id[r][c]);
        ey[r*GX+c] = rh;
        ex[r*GX+c] = rh && ch;
      end
    end
  endfunction

  task automatic drive_word(input logic [15:0] d, input int rt, input int ct);
    i_in_valid   = 1'b1;
    i_in_data    = d;
    i_in_row_tag = 4'(rt);
    i_in_col_tag = 5'(ct);
  endtask

  task automatic program_ids(input bit rnd, output int pulses, output logic done_last);
    int vals [NPE+GY];
    pulses = 0;
    done_last = 1'b0;
    for (int k = 0; k < GY; k++) vals[k] = rnd ? int'($urandom_range(0, 15)) : k;
    for (int k = 0; k < NPE; k++) vals[GY+k] = rnd ? int'($urandom_range(0, 31)) : (k % GX);
    i_prog_start = 1'b1;
    tick();
    i_prog_start = 1'b0;
    for (int k = 0; k < NPE + GY; k++) begin
      i_cfg_valid = 1'b1;
      i_cfg_id    = 5'(vals[k]);
      if (k < GY) m_row_id[k] = vals[k];
      else m_col_id[(k-GY)/GX][(k-GY)%GX] = vals[k];
      tick();
      if (o_prog_done) pulses++;
      if (k == NPE + GY - 1) done_last = o_prog_done;
    end
    i_cfg_valid = 1'b0;
    i_cfg_id = '0;
  endtask

  task automatic test_reset();
    i_rstb = 1'b0;
    tick();
    tick();
    checks++;
    if (o_out_valid !== 1'b0 || o_out_data !== 16'sd0 || o_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b data=%h ready=%b required 0/0000/0",
               o_out_valid, o_out_data, o_in_ready);
    end
    checks++;
    if (o_enable_x !== '0 || o_enable_y !== '0 || o_prog_done !== 1'b0 || o_nomatch !== 1'b0) begin
      failures++;
      $display("FAIL reset_enables: ex=%h ey=%h done=%b nomatch=%b required all 0",
               o_enable_x, o_enable_y, o_prog_done, o_nomatch);
    end
    i_rstb = 1'b1;
    tick();
  endtask

  task automatic test_program();
    int pulses;
    logic done_last;
    program_ids(1'b0, pulses, done_last);
    checks++;
    if (done_last !== 1'b1) begin
      failures++;
      $display("FAIL prog_done_last: got %b required 1", done_last);
    end
    checks++;
    if (o_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL prog_in_ready: got %b required 1", o_in_ready);
    end
    tick();
    if (o_prog_done) pulses++;
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL prog_done_count: got %0d required 1", pulses);
    end
  endtask

  task automatic test_unicast();
    logic [NPE-1:0] ey, ex, cx, cy;
    cx = '0;
    cx[37] = 1'b1;
    cy = '0;
    for (int i = 30; i < 40; i++) cy[i] = 1'b1;
    i_pe_ready = '1;
    calc_en(3, 7, ey, ex);
    drive_word(16'h1234, 3, 7);
    tick();
    i_in_valid = 1'b0;
    checks++;
    if (o_out_valid !== 1'b1 || o_out_data !== 16'sh1234) begin
      failures++;
      $display("FAIL unicast_data: valid=%b data=%h required 1/1234", o_out_valid, o_out_data);
    end
    checks++;
    if (o_enable_x !== cx || o_enable_x !== ex) begin
      failures++;
      $display("FAIL unicast_enable_x: got %h required %h", o_enable_x, cx);
    end
    checks++;
    if (o_enable_y !== cy || o_enable_y !== ey) begin
      failures++;
      $display("FAIL unicast_enable_y: got %h required %h", o_enable_y, cy);
    end
    tick();
    checks++;
    if (o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL unicast_fire: out_valid=%b required 0", o_out_valid);
    end
  endtask

  task automatic test_multicast();
    logic [NPE-1:0] ey, ex, c1, c2;
    c1 = '0;
    for (int i = 20; i < 30; i++) c1[i] = 1'b1;
    c2 = '0;
    for (int r = 0; r < GY; r++) c2[r*GX+4] = 1'b1;
    calc_en(2, 31, ey, ex);
    drive_word(16'h0A0A, 2, 31);
    tick();
    i_in_valid = 1'b0;
    checks++;
    if (o_enable_x !== c1 || o_enable_x !== ex || o_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL multicast_col_wild: ex=%h valid=%b required %h/1", o_enable_x, o_out_valid, c1);
    end
    tick();
    calc_en(15, 4, ey, ex);
    drive_word(16'h0B0B, 15, 4);
    tick();
    i_in_valid = 1'b0;
    checks++;
    if (o_enable_x !== c2 || o_enable_x !== ex || o_enable_y !== '1) begin
      failures++;
      $display("FAIL multicast_row_wild: ex=%h ey=%h required %h/all", o_enable_x, o_enable_y, c2);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] d [4];
    i_pe_ready = '1;
    for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      drive_word(d[i], i, i + 1);
      #1;
      checks++;
      if (o_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: got %b required 1", i, o_in_ready);
      end
      tick();
      checks++;
      if (o_out_data !== d[i] || o_out_valid !== 1'b1 || o_enable_x[i*GX+i+1] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_word[%0d]: data=%h valid=%b required %h/1", i, o_out_data, o_out_valid, d[i]);
      end
    end
    i_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [NPE-1:0] held_x;
    i_pe_ready = '1;
    i_pe_ready[37] = 1'b0;
    drive_word(16'h5555, 3, 7);
    tick();
    held_x = o_enable_x;
    drive_word(16'h6666, 1, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_out_data !== 16'sh5555 || o_enable_x !== held_x) begin
        failures++;
        $display("FAIL bp_hold[%0d]: ready=%b valid=%b data=%h required 0/1/5555", i, o_in_ready, o_out_valid, o_out_data);
      end
      tick();
    end
    i_pe_ready[37] = 1'b1;
    #1;
    checks++;
    if (o_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %b required 1", o_in_ready);
    end
    tick();
    i_in_valid = 1'b0;
    checks++;
    if (o_out_data !== 16'sh6666 || o_out_valid !== 1'b1 || o_enable_x[11] !== 1'b1) begin
      failures++;
      $display("FAIL bp_next_word: data=%h valid=%b required 6666/1", o_out_data, o_out_valid);
    end
    tick();
  endtask

  task automatic test_nomatch();
    drive_word(16'h7777, 12, 3);
    #1;
    checks++;
    if (o_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL nomatch_ready: got %b required 1", o_in_ready);
    end
    tick();
    i_in_valid = 1'b0;
    checks++;
    if (o_nomatch !== 1'b1 || o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL nomatch_pulse: nomatch=%b valid=%b required 1/0", o_nomatch, o_out_valid);
    end
    tick();
    checks++;
    if (o_nomatch !== 1'b0) begin
      failures++;
      $display("FAIL nomatch_width: got %b required 0", o_nomatch);
    end
  endtask

  task automatic test_drain_and_reset();
    i_pe_ready = '1;
    i_pe_ready[37] = 1'b0;
    drive_word(16'h1111, 3, 7);
    tick();
    i_in_valid = 1'b0;
    i_prog_start = 1'b1;
    tick();
    i_prog_start = 1'b0;
    tick();
    checks++;
    if (dut.r_state !== ST_DRAIN || o_in_ready !== 1'b0 || o_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL drain_enter: state=%0d ready=%b valid=%b required DRAIN/0/1", dut.r_state, o_in_ready, o_out_valid);
    end
    i_pe_ready[37] = 1'b1;
    tick();
    checks++;
    if (dut.r_state !== ST_PROG || o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_exit: state=%0d valid=%b required PROG/0", dut.r_state, o_out_valid);
    end
    for (int k = 0; k < 3; k++) begin
      i_cfg_valid = 1'b1;
      i_cfg_id = 5'd9;
      tick();
    end
    i_cfg_valid = 1'b0;
    #2;
    i_rstb = 1'b0;
    #1;
    checks++;
    if (dut.r_state !== ST_IDLE || o_in_ready !== 1'b0 || o_out_valid !== 1'b0 ||
        o_enable_x !== '0 || o_enable_y !== '0 || o_out_data !== 16'sd0) begin
      failures++;
      $display("FAIL async_reset: state=%0d ready=%b valid=%b data=%h required IDLE/0/0/0000",
               dut.r_state, o_in_ready, o_out_valid, o_out_data);
    end
    checks++;
    if (dut.g_row[0].u_row.r_row_id !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_ids: row_id0=%0d required 0", dut.g_row[0].u_row.r_row_id);
    end
    tick();
    i_rstb = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int pulses;
    logic done_last;
    bit m_valid;
    logic [15:0] m_data;
    logic [NPE-1:0] m_ex, m_ey;
    bit m_nomatch;
    program_ids(1'b1, pulses, done_last);
    checks++;
    if (done_last !== 1'b1 || pulses != 1) begin
      failures++;
      $display("FAIL rand_prog: done_last=%b pulses=%0d required 1/1", done_last, pulses);
    end
    m_valid = 0;
    m_data = '0;
    m_ex = '0;
    m_ey = '0;
    m_nomatch = 0;
    for (int n = 0; n < 400; n++) begin
      logic [NPE-1:0] ey, ex;
      bit fire, rdy, acc;
      int rt, ct;
      logic [15:0] d;
      int r0;
      r0 = $urandom_range(0, GY-1);
      rt = ($urandom_range(0, 7) == 0) ? 15 :
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : m_row_id[r0];
      ct = ($urandom_range(0, 7) == 0) ? 31 :
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : m_col_id[r0][$urandom_range(0, GX-1)];
      d = 16'($urandom);
      i_in_valid = ($urandom_range(0, 3) != 0);
      i_in_data = d;
      i_in_row_tag = 4'(rt);
      i_in_col_tag = 5'(ct);
      if ($urandom_range(0, 1) == 1) i_pe_ready = '1;
      else for (int i = 0; i < NPE; i++) i_pe_ready[i] = ($urandom_range(0, 15) != 0);
      #1;
      fire = m_valid && ((m_ex & ~i_pe_ready) == '0);
      rdy  = !m_valid || fire;
      acc  = i_in_valid && rdy;
      calc_en(rt, ct, ey, ex);
      checks++;
      if (o_in_ready !== rdy) begin
        failures++;
        $display("FAIL rand_ready[%0d]: got %b required %b", n, o_in_ready, rdy);
      end
      tick();
      if (acc) begin
        m_data = d;
        m_ex = ex;
        m_ey = ey;
        m_valid = (ex != '0);
        m_nomatch = (ex == '0);
      end else begin
        if (fire) m_valid = 0;
        m_nomatch = 0;
      end
      checks++;
      if (o_out_valid !== m_valid || o_nomatch !== m_nomatch || o_enable_x !== m_ex ||
          o_enable_y !== m_ey || (m_valid && o_out_data !== m_data)) begin
        failures++;
        $display("FAIL rand_out[%0d]: valid=%b nomatch=%b data=%h required %b/%b/%h",
                 n, o_out_valid, o_nomatch, o_out_data, m_valid, m_nomatch, m_data);
      end
    end
    i_in_valid = 1'b0;
    i_pe_ready = '1;
    tick();
  endtask

  initial begin
    test_reset();
    test_program();
    test_unicast();
    test_multicast();
    test_back_to_back();
    test_backpressure();
    test_nomatch();
    test_drain_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
